// File: rtl/ahb_spi_pkg.sv
// Shared definitions for the AHB-Lite SPI master slave.
//   - Word-index constants for the register map (HADDR[4:2]).
//   - Shift engine FSM state encoding.
//   - SPI_BITS: bits per SPI transfer.
package ahb_spi_pkg;

    localparam logic [2:0] REG_START = 3'd0;
    localparam logic [2:0] REG_SS    = 3'd1;
    localparam logic [2:0] REG_READY = 3'd2;
    localparam logic [2:0] REG_DATA  = 3'd4;

    localparam int SPI_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Byte-wide SPI master shift engine, mode 0 (SCK idles low, MOSI changes on
// the falling edge, MISO sampled on the rising edge), MSB first.
// Ports:
//   HCLK, HRESET       clock, synchronous active-high reset
//   start              one-cycle request, honoured only while idle
//   tx_byte            byte loaded into the shifter on start
//   busy               high while a transfer is in progress
//   done_pulse         one-cycle pulse in the last cycle of a transfer
//   rx_byte            received byte, complete when done_pulse is high
//   SPI_SCK/MOSI/MISO  SPI pins (slave select is handled outside)
module spi_shift_engine
    import ahb_spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                start,
    input  logic [SPI_BITS-1:0] tx_byte,
    output logic                busy,
    output logic                done_pulse,
    output logic [SPI_BITS-1:0] rx_byte,
    output logic                SPI_SCK,
    output logic                SPI_MOSI,
    input  logic                SPI_MISO
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SPI_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SPI_BITS - 1);

    spi_state_e          state;
    spi_state_e          state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SPI_BITS-1:0] shift_reg;
    logic [SPI_BITS-1:0] rx_shift;
    logic                phase_end;

    // Last HCLK cycle of the current SCK half-period.
    assign phase_end = (div_cnt == DIV_LAST);
    assign busy      = (state != IDLE);
    assign rx_byte   = rx_shift;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_next = IDLE;
                        done_pulse = 1'b1;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and pin registers; these carry the reset values seen on the pins.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            SPI_SCK  <= 1'b0;
            SPI_MOSI <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        SPI_MOSI <= tx_byte[SPI_BITS-1];
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        SPI_SCK <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        SPI_SCK <= 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            // shift_reg[MSB] is the bit just sent; the next one sits below it.
                            SPI_MOSI <= shift_reg[SPI_BITS-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Data shifters; contents are meaningless until a transfer loads them.
    always_ff @(posedge HCLK) begin
        if (state == IDLE && start) begin
            shift_reg <= tx_byte;
        end
        if (state == LOW && phase_end) begin
            rx_shift <= {rx_shift[SPI_BITS-2:0], SPI_MISO};
        end
        if (state == HIGH && phase_end && bit_cnt != BIT_LAST) begin
            shift_reg <= {shift_reg[SPI_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ahb_spi_slave.sv
// AHB-Lite slave exposing a byte-wide SPI master through four word registers
// (START, SS, READY, DATA). Zero wait states, always OKAY. Slave select is
// driven purely by software through the SS register.
// Ports:
//   HCLK, HRESET                   clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE,
//   HSIZE, HWDATA, HREADY          AHB-Lite slave inputs (HSIZE ignored)
//   HRDATA, HREADYOUT, HRESP       AHB-Lite slave outputs
//   SPI_SCK, SPI_CS_N, SPI_MOSI,
//   SPI_MISO                       SPI master pins
module ahb_spi_slave
    import ahb_spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        SPI_SCK,
    output logic        SPI_CS_N,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    logic                addr_vld;
    logic                dp_vld;
    logic                dp_write;
    logic [2:0]          dp_idx;
    logic                wr_en;
    logic                start;
    logic                busy;
    logic                done_pulse;
    logic                done;
    logic                cs_n;
    logic [SPI_BITS-1:0] tx_hold;
    logic [SPI_BITS-1:0] rx_data;
    logic [SPI_BITS-1:0] rx_byte;
    logic                unused_bits;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign SPI_CS_N  = cs_n;

    assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

    // Address phase -> data phase.
    assign addr_vld = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
        end else if (HREADY) begin
            dp_vld   <= addr_vld;
            dp_write <= HWRITE;
            dp_idx   <= HADDR[4:2];
        end
    end

    // Writes commit on the last cycle of the data phase (HREADY high).
    assign wr_en = dp_vld & dp_write & HREADY;
    assign start = wr_en && (dp_idx == REG_START) && HWDATA[0] && !busy;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cs_n    <= 1'b1;
            tx_hold <= '0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            if (wr_en && dp_idx == REG_SS) begin
                cs_n <= HWDATA[0];
            end
            if (wr_en && dp_idx == REG_DATA && !busy) begin
                tx_hold <= HWDATA[SPI_BITS-1:0];
            end
            // start requires !busy and done_pulse only occurs while busy,
            // so the two never coincide.
            if (start) begin
                done <= 1'b0;
            end else if (done_pulse) begin
                done <= 1'b1;
            end
            if (done_pulse) begin
                rx_data <= rx_byte;
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_vld && !dp_write) begin
            case (dp_idx)
                REG_START: HRDATA[0]            = busy;
                REG_SS:    HRDATA[0]            = cs_n;
                REG_READY: HRDATA[0]            = done;
                REG_DATA:  HRDATA[SPI_BITS-1:0] = rx_data;
                default:   HRDATA               = '0;
            endcase
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .tx_byte    (tx_hold),
        .busy       (busy),
        .done_pulse (done_pulse),
        .rx_byte    (rx_byte),
        .SPI_SCK    (SPI_SCK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO)
    );

endmodule

// File: tb/tb_ahb_spi_slave.sv
`timescale 1ns/1ps
module tb_ahb_spi_slave;
    import ahb_spi_pkg::*;

    localparam int DIV   = 4;
    localparam int XFER  = 16 * DIV;
    localparam int NEVER = 32'h3fffffff;
    localparam logic [31:0] BASE = 32'hbf000000;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        SPI_SCK;
    logic        SPI_CS_N;
    logic        SPI_MOSI;
    logic        SPI_MISO;

    ahb_spi_slave #(.CLK_DIV(DIV)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .SPI_SCK   (SPI_SCK),
        .SPI_CS_N  (SPI_CS_N),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO)
    );

    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;

    // Pin monitor: cycle counter, SCK edge times and MOSI at each rise.
    int   cyc = 0;
    int   rise_cnt = 0;
    int   rise_base = 0;
    logic sck_prev = 1'b0;
    int   rise_q[$];
    int   fall_q[$];
    logic mosi_q[$];
    int   xq_rise = 0;
    int   xq_fall = 0;

    always @(posedge HCLK) begin
        cyc      <= cyc + 1;
        sck_prev <= SPI_SCK;
        if (!sck_prev && SPI_SCK) begin
            rise_q.push_back(cyc);
            mosi_q.push_back(SPI_MOSI);
            rise_cnt <= rise_cnt + 1;
        end
        if (sck_prev && !SPI_SCK) begin
            fall_q.push_back(cyc);
        end
    end

    // SPI slave model: presents miso_byte MSB first, next bit after each rise.
    logic [7:0] miso_byte = 8'h00;
    logic [2:0] miso_idx;
    assign miso_idx = 3'(7 - (rise_cnt - rise_base));
    assign SPI_MISO = miso_byte[miso_idx];

    // Register-level reference model, indexed by bus cycle number.
    logic [7:0] m_tx, m_sent, m_rx_prev, m_rx_next;
    logic       m_cs;
    int         m_start, m_busy_end, m_done_at;

    task automatic model_reset();
        m_tx = 8'h00; m_sent = 8'h00; m_rx_prev = 8'h00; m_rx_next = 8'h00;
        m_cs = 1'b1; m_start = -100; m_busy_end = 0; m_done_at = NEVER;
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input int c);
        case (idx)
            REG_START: begin
                if (d[0] && c >= m_busy_end) begin
                    m_rx_prev  = m_rx_next;
                    m_rx_next  = miso_byte;
                    m_sent     = m_tx;
                    m_start    = c;
                    m_busy_end = c + 1 + XFER;
                    m_done_at  = m_busy_end;
                end
            end
            REG_SS:   m_cs = d[0];
            REG_DATA: if (c >= m_busy_end) m_tx = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] idx, input int c);
        logic [31:0] r;
        r = '0;
        case (idx)
            REG_START: r[0]   = (c > m_start) && (c < m_busy_end);
            REG_SS:    r[0]   = m_cs;
            REG_READY: r[0]   = (c >= m_done_at);
            REG_DATA:  r[7:0] = (c >= m_busy_end) ? m_rx_next : m_rx_prev;
            default:   r      = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] addr_of(input logic [2:0] idx);
        return BASE | {27'd0, idx, 2'b00};
    endfunction

    // Bus drivers: addr phase in one cycle, data phase in the next.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        model_write(addr[4:2], data, cyc);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data, output int c);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b0; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        c = cyc;
        data = HRDATA;
    endtask

    task automatic start_xfer(input logic [7:0] mb);
        miso_byte = mb;
        rise_base = rise_cnt;
        xq_rise   = rise_q.size();
        xq_fall   = fall_q.size();
        ahb_write(addr_of(REG_START), 32'h1);
    endtask

    // Polls READY to completion, then checks waveform shape, MOSI byte and DATA.
    task automatic finish_xfer(input string name);
        logic [31:0] rd;
        logic [7:0]  sent;
        int          c;
        bit          seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            ahb_read(addr_of(REG_READY), rd, c);
            tests++;
            if (rd !== exp_read(REG_READY, c)) begin
                fails++;
                $display("FAIL %s_ready cyc %0d: got %h expected %h", name, c, rd, exp_read(REG_READY, c));
            end
            if (rd[0] === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: READY never set, expected at cycle %0d", name, m_done_at);
        end
        ahb_read(addr_of(REG_DATA), rd, c);
        tests++;
        if (rd !== exp_read(REG_DATA, c)) begin
            fails++;
            $display("FAIL %s_data: got %h expected %h", name, rd, exp_read(REG_DATA, c));
        end
        tests++;
        if ((rise_q.size() - xq_rise) !== 8 || (fall_q.size() - xq_fall) !== 8) begin
            fails++;
            $display("FAIL %s_pulses: rises %0d falls %0d expected 8 each", name,
                     rise_q.size() - xq_rise, fall_q.size() - xq_fall);
        end else begin
            sent = 8'h00;
            for (int i = 0; i < 8; i++) begin
                sent = {sent[6:0], mosi_q[xq_rise + i]};
                tests++;
                if (rise_q[xq_rise + i] !== m_start + 1 + DIV + 2 * DIV * i ||
                    fall_q[xq_fall + i] !== m_start + 1 + 2 * DIV * (i + 1)) begin
                    fails++;
                    $display("FAIL %s_sck_edge%0d: rise %0d fall %0d expected rise %0d fall %0d", name, i,
                             rise_q[xq_rise + i], fall_q[xq_fall + i],
                             m_start + 1 + DIV + 2 * DIV * i, m_start + 1 + 2 * DIV * (i + 1));
                end
            end
            tests++;
            if (sent !== m_sent) begin
                fails++;
                $display("FAIL %s_mosi: got %h expected %h", name, sent, m_sent);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          c;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        model_reset();
        tests++;
        if ({SPI_SCK, SPI_CS_N, SPI_MOSI, HREADYOUT, HRESP, HRDATA} !== {5'b01010, 32'h0}) begin
            fails++;
            $display("FAIL reset_pins: sck %b cs_n %b mosi %b hreadyout %b hresp %b hrdata %h expected 0 1 0 1 0 0",
                     SPI_SCK, SPI_CS_N, SPI_MOSI, HREADYOUT, HRESP, HRDATA);
        end
        for (int i = 0; i < 8; i++) begin
            ahb_read(addr_of(3'(i)), rd, c);
            tests++;
            if (rd !== exp_read(3'(i), c) || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h rdy %b resp %b expected %h rdy 1 resp 0",
                         i, rd, HREADYOUT, HRESP, exp_read(3'(i), c));
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] tx;
        ahb_write(addr_of(REG_SS), 32'h0);
        @(posedge HCLK); #1;
        tests++;
        if (SPI_CS_N !== m_cs) begin
            fails++;
            $display("FAIL basic_cs_n: got %b expected %b", SPI_CS_N, m_cs);
        end
        ahb_write(addr_of(REG_DATA), 32'hAA);
        start_xfer(8'h3C);
        finish_xfer("basic");
        for (int k = 0; k < 4; k++) begin
            tx = 8'($urandom);
            ahb_write(addr_of(REG_DATA), {24'($urandom), tx});
            start_xfer(8'($urandom));
            finish_xfer("random");
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd;
        int          c;
        ahb_write(addr_of(REG_DATA), 32'h33);
        start_xfer(8'hC5);
        repeat (6) @(posedge HCLK);
        ahb_write(addr_of(REG_DATA), 32'h55);
        ahb_write(addr_of(REG_START), 32'h1);
        ahb_read(addr_of(REG_START), rd, c);
        tests++;
        if (rd !== exp_read(REG_START, c)) begin
            fails++;
            $display("FAIL busy_flag: got %h expected %h", rd, exp_read(REG_START, c));
        end
        finish_xfer("busy");
        repeat (4 * DIV) @(posedge HCLK);
        #1;
        tests++;
        if ((rise_q.size() - xq_rise) !== 8) begin
            fails++;
            $display("FAIL busy_single: rises %0d expected 8", rise_q.size() - xq_rise);
        end
        ahb_read(addr_of(REG_READY), rd, c);
        tests++;
        if (rd !== exp_read(REG_READY, c)) begin
            fails++;
            $display("FAIL busy_ready_hold: got %h expected %h", rd, exp_read(REG_READY, c));
        end
        start_xfer(8'h5A);
        finish_xfer("retransmit");
    endtask

    task automatic test_alias();
        logic [31:0] r1, r2;
        int          c1, c2;
        ahb_write(BASE + 32'h12, 32'hFF);
        start_xfer(8'($urandom));
        finish_xfer("alias");
        ahb_read(BASE + 32'h12, r1, c1);
        ahb_read(BASE + 32'h10, r2, c2);
        tests++;
        if (r1 !== r2 || r1 !== exp_read(REG_DATA, c1)) begin
            fails++;
            $display("FAIL alias_read: 0x12 got %h 0x10 got %h expected %h", r1, r2, exp_read(REG_DATA, c1));
        end
        ahb_read(BASE + 32'h0C, r1, c1);
        tests++;
        if (r1 !== exp_read(3'd3, c1) || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            fails++;
            $display("FAIL alias_unmapped: got %h resp %b rdy %b expected 0 resp 0 rdy 1", r1, HRESP, HREADYOUT);
        end
        ahb_write(BASE + 32'h1C, 32'h1);
        ahb_read(addr_of(REG_START), r1, c1);
        tests++;
        if (r1 !== exp_read(REG_START, c1)) begin
            fails++;
            $display("FAIL alias_idx7_start: got %h expected %h", r1, exp_read(REG_START, c1));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          c;
        int          n;
        ahb_write(addr_of(REG_DATA), 32'($urandom));
        start_xfer(8'($urandom));
        n = 0;
        while (rise_cnt - rise_base < 3 && n < 200) begin
            @(posedge HCLK);
            n++;
        end
        tests++;
        if (rise_cnt - rise_base < 3) begin
            fails++;
            $display("FAIL midreset_wait: rises %0d expected 3", rise_cnt - rise_base);
        end
        #1 HRESET = 1'b1;
        @(posedge HCLK); #1;
        tests++;
        if ({SPI_SCK, SPI_CS_N, SPI_MOSI} !== 3'b010) begin
            fails++;
            $display("FAIL midreset_pins: sck %b cs_n %b mosi %b expected 0 1 0", SPI_SCK, SPI_CS_N, SPI_MOSI);
        end
        HRESET = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) continue;
            ahb_read(addr_of(3'(i)), rd, c);
            tests++;
            if (rd !== exp_read(3'(i), c)) begin
                fails++;
                $display("FAIL midreset_reg%0d: got %h expected %h", i, rd, exp_read(3'(i), c));
            end
        end
        ahb_write(addr_of(REG_SS), 32'h0);
        ahb_write(addr_of(REG_DATA), 32'h96);
        start_xfer(8'h69);
        finish_xfer("after_reset");
    endtask

    task automatic test_hready();
        logic [31:0] rd;
        int          c;
        // SS write whose address phase is stalled by another slave.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr_of(REG_SS); HWRITE = 1'b1; HREADY = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HWDATA = 32'h1;
        @(posedge HCLK); #1;
        HWDATA = 32'h0;
        @(posedge HCLK); #1;
        tests++;
        if (SPI_CS_N !== m_cs) begin
            fails++;
            $display("FAIL hready_cs_n: got %b expected %b", SPI_CS_N, m_cs);
        end
        // Same for DATA: tx_hold must keep the previously loaded byte.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr_of(REG_DATA); HWRITE = 1'b1; HREADY = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HWDATA = {24'h0, ~m_tx};
        ahb_read(addr_of(REG_SS), rd, c);
        tests++;
        if (rd !== exp_read(REG_SS, c)) begin
            fails++;
            $display("FAIL hready_ss_read: got %h expected %h", rd, exp_read(REG_SS, c));
        end
        start_xfer(8'($urandom));
        finish_xfer("hready");
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = BASE; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_busy();
        test_alias();
        test_reset_mid();
        test_hready();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
